ram_arbiter: RTL and testbench

//   Shares one single-port RAM (sync write, combinational read) between N requesters.

---
 rtl/ram_arbiter_pkg.sv | 30 +++
 rtl/ram_arbiter_rr_pick.sv | 52 +++++
 rtl/ram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_arbiter_pkg
//   Shared helpers for the RAM arbiter and its round-robin picker.
//   - MAX_REQ       : widest requester vector the helpers accept.
//   - idx_width()   : bits needed to hold an index into an n-entry vector
//                     (never less than 1, so N=1 style corners stay legal).
//   - onehot_to_idx : converts a one-hot vector to its bit position.
// ---------------------------------------------------------------------------
package ram_arbiter_pkg;

    localparam int unsigned MAX_REQ = 32;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // ORing the positions of all set bits gives the index for a one-hot
    // input, and 0 for an all-zero input, with no priority chain.
    function automatic int unsigned onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Finds the first set request bit when
//   scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//   Ports:
//     req_i  [N-1:0]   request vector
//     ptr_i  [IW-1:0]  index with highest priority this cycle
//     gnt_o  [N-1:0]   one-hot winner (all zero when req_i is zero)
//     idx_o  [IW-1:0]  index of the winner (0 when nothing is granted)
//   N must not exceed MAX_REQ.
// ---------------------------------------------------------------------------
module rr_pick
    import ram_arbiter_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    // The request vector is duplicated so the wrap-around scan becomes a
    // plain LSB-first search: bits below ptr in the lower copy are masked
    // off, and their second chance comes from the upper copy.
    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] masked;
    logic           found;

    always_comb begin
        req_dbl = {req_i, req_i};
        mask    = '0;
        for (int k = 0; k < 2*N; k++) begin
            mask[k] = (k >= int'(ptr_i));
        end
        masked = req_dbl & mask;

        gnt_o = '0;
        found = 1'b0;
        for (int k = 0; k < 2*N; k++) begin
            if (!found && masked[k]) begin
                found          = 1'b1;
                gnt_o[k % N]   = 1'b1;
            end
        end

        idx_o = IW'(onehot_to_idx(MAX_REQ'(gnt_o)));
    end

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//   Shares one single-port RAM (synchronous write, combinational read)
//   between Requesters clients with round-robin arbitration and an optional
//   ownership lock for back-to-back bursts. One access is granted per cycle;
//   read data is registered and returned one cycle after the grant.
//
//   Handshake: req[i] is a level held until gnt[i]. A cycle with gnt[i]=1
//   completes requester i's access at the next rising clk edge; a requester
//   that keeps req high issues another access and is re-arbitrated. For a
//   read, rvalid[i] pulses for one cycle after that edge with rdata valid;
//   writes are acknowledged by gnt alone.
//
//   Ports:
//     clk, rst                     clock (rising edge), async active-high reset
//     req/req_we/req_lock [N]      request, write select, keep-ownership
//     req_addr  [N*AddressSize]    requester i at [i*AddressSize +: AddressSize]
//     req_wdata [N*Width]          requester i at [i*Width +: Width]
//     gnt       [N]                one-hot grant (combinational)
//     rvalid    [N]                one-hot read return, 1 cycle after gnt
//     rdata     [Width]            registered read data, holds when idle
//     ram_we/ram_addr/ram_d        muxed RAM controls (zero when idle)
//     ram_q                        RAM read data
//     dbg_ptr/dbg_owner/dbg_owner_valid   arbitration state, for observation
// ---------------------------------------------------------------------------
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter  int Requesters  = 4,
    parameter  int Width       = 8,
    parameter  int AddressSize = 4,
    localparam int IW          = idx_width(Requesters)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [Requesters-1:0]           req,
    input  logic [Requesters-1:0]           req_we,
    input  logic [Requesters-1:0]           req_lock,
    input  logic [Requesters*AddressSize-1:0] req_addr,
    input  logic [Requesters*Width-1:0]     req_wdata,
    output logic [Requesters-1:0]           gnt,
    output logic [Requesters-1:0]           rvalid,
    output logic [Width-1:0]                rdata,
    output logic                            ram_we,
    output logic [AddressSize-1:0]          ram_addr,
    output logic [Width-1:0]                ram_d,
    input  logic [Width-1:0]                ram_q,
    output logic [IW-1:0]                   dbg_ptr,
    output logic [IW-1:0]                   dbg_owner,
    output logic                            dbg_owner_valid
);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic                  owner_valid_q, owner_valid_d;
    logic [Requesters-1:0] rvalid_q, rvalid_d;
    logic [Width-1:0]      rdata_q, rdata_d;

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    logic [Requesters-1:0] rr_gnt;
    logic [IW-1:0]         rr_idx;
    logic [Requesters-1:0] owner_oh;
    logic [Requesters-1:0] gnt_int;
    logic [IW-1:0]         g;
    logic                  owner_hit;
    logic                  any_gnt;
    logic                  g_we;

    rr_pick #(
        .N (Requesters)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx)
    );

    // A locked owner wins only while it still requests; once it drops req
    // the round-robin result is used in that very cycle.
    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_q] = 1'b1;
        owner_hit         = owner_valid_q & req[owner_q];

        if (owner_hit) begin
            gnt_int = owner_oh;
            g       = owner_q;
        end else begin
            gnt_int = rr_gnt;
            g       = rr_idx;
        end

        any_gnt = |gnt_int;
        g_we    = any_gnt & req_we[g];
    end

    // ---------------------------------------------------------------------
    // RAM port mux
    // ---------------------------------------------------------------------
    always_comb begin
        ram_we   = g_we;
        ram_addr = '0;
        ram_d    = '0;
        if (any_gnt) begin
            ram_addr = req_addr[int'(g)*AddressSize +: AddressSize];
            ram_d    = req_wdata[int'(g)*Width +: Width];
        end
    end

    assign gnt = gnt_int;

    // ---------------------------------------------------------------------
    // Next state
    // ---------------------------------------------------------------------
    always_comb begin
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        rvalid_d      = '0;
        rdata_d       = rdata_q;

        if (any_gnt) begin
            // The pointer moves past the winner even during a locked burst,
            // so the others get their turn as soon as the lock is released.
            if (g == IW'(Requesters - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = g + 1'b1;
            end

            if (req_lock[g]) begin
                owner_d       = g;
                owner_valid_d = 1'b1;
            end else begin
                owner_valid_d = 1'b0;
            end

            // The RAM read is combinational, so ram_q already reflects the
            // granted address (including a write completed the edge before).
            if (!req_we[g]) begin
                rvalid_d = gnt_int;
                rdata_d  = ram_q;
            end
        end else begin
            // No grant means no requests at all, so the owner has let go.
            owner_valid_d = owner_hit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q         <= '0;
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            rvalid_q      <= '0;
            rdata_q       <= '0;
        end else begin
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
        end
    end

    assign rvalid          = rvalid_q;
    assign rdata           = rdata_q;
    assign dbg_ptr         = ptr_q;
    assign dbg_owner       = owner_q;
    assign dbg_owner_valid = owner_valid_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//   Directed bench for ram_arbiter (N=4, Width=8, AddressSize=4) with a
//   behavioural RAM attached. Each arbitration cycle checks the grant and
//   RAM controls; read grants push {one-hot rvalid, data} from a shadow
//   memory onto exp_q, popped and compared after the next edge.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int AW = 4;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    req, req_we, req_lock;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0]  req_wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [W-1:0]    rdata;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [W-1:0]    ram_d, ram_q;
    logic [1:0]      dbg_ptr, dbg_owner;
    logic            dbg_owner_valid;

    ram_arbiter #(
        .Requesters  (N),
        .Width       (W),
        .AddressSize (AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_we          (req_we),
        .req_lock        (req_lock),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .gnt             (gnt),
        .rvalid          (rvalid),
        .rdata           (rdata),
        .ram_we          (ram_we),
        .ram_addr        (ram_addr),
        .ram_d           (ram_d),
        .ram_q           (ram_q),
        .dbg_ptr         (dbg_ptr),
        .dbg_owner       (dbg_owner),
        .dbg_owner_valid (dbg_owner_valid)
    );

    // Attached RAM: synchronous write, combinational read.
    logic [W-1:0] mem [16];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_d;
    end
    assign ram_q = mem[ram_addr];

    // ---------------------------------------------------------------------
    // Scoreboard
    // ---------------------------------------------------------------------
    logic [N+W-1:0] exp_q[$];
    logic [W-1:0]   shadow [16];
    logic [W-1:0]   last_rdata;
    int             checks   = 0;
    int             failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic set_req(input int i, input bit r, input bit we, input bit lock,
                           input logic [AW-1:0] addr, input logic [W-1:0] d);
        req[i]                = r;
        req_we[i]             = we;
        req_lock[i]           = lock;
        req_addr[i*AW +: AW]  = addr;
        req_wdata[i*W +: W]   = d;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // One arbitration cycle: entered just after a rising edge with inputs set.
    task automatic cycle(input string tag, input logic [N-1:0] exp_gnt);
        int            g;
        logic [AW-1:0] a;
        logic [N-1:0]  oh;
        logic [N+W-1:0] e;
        #1;
        chk($sformatf("%s_gnt", tag), 32'(gnt), 32'(exp_gnt));
        g = -1;
        for (int i = 0; i < N; i++) if (exp_gnt[i]) g = i;
        if (g >= 0) begin
            a = req_addr[g*AW +: AW];
            chk($sformatf("%s_ram_we", tag), 32'(ram_we), 32'(req_we[g]));
            chk($sformatf("%s_ram_addr", tag), 32'(ram_addr), 32'(a));
            if (req_we[g]) begin
                chk($sformatf("%s_ram_d", tag), 32'(ram_d), 32'(req_wdata[g*W +: W]));
                shadow[a] = req_wdata[g*W +: W];
            end else begin
                oh    = '0;
                oh[g] = 1'b1;
                exp_q.push_back({oh, shadow[a]});
            end
        end else begin
            chk($sformatf("%s_idle_we", tag), 32'(ram_we), 32'd0);
            chk($sformatf("%s_idle_addr", tag), 32'(ram_addr), 32'd0);
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("%s_rvalid", tag), 32'(rvalid), 32'(e[N+W-1:W]));
            chk($sformatf("%s_rdata", tag), 32'(rdata), 32'(e[W-1:0]));
            last_rdata = e[W-1:0];
        end else begin
            chk($sformatf("%s_no_rvalid", tag), 32'(rvalid), 32'd0);
            chk($sformatf("%s_rdata_hold", tag), 32'(rdata), 32'(last_rdata));
        end
    endtask

    // ---------------------------------------------------------------------
    // Directed sequence
    // ---------------------------------------------------------------------
    initial begin
        logic [W-1:0] d;
        req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        last_rdata = '0;
        for (int i = 0; i < 16; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end

        // 1. Reset state, then idle cycles.
        #7;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ptr", 32'(dbg_ptr), 32'd0);
        chk("rst_owner_valid", 32'(dbg_owner_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) cycle("t1_idle", 4'b0000);

        // 2. Write then read the same address from requester 0.
        set_req(0, 1'b1, 1'b1, 1'b0, 4'd3, 8'hA5);
        cycle("t2_wr", 4'b0001);
        set_req(0, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
        cycle("t2_rd", 4'b0001);
        clear_reqs();
        chk("t2_ptr", 32'(dbg_ptr), 32'd1);

        // Asynchronous reset pulse between edges returns ptr to 0.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        last_rdata = '0;
        chk("t2_rst_ptr", 32'(dbg_ptr), 32'd0);
        chk("t2_rst_rdata", 32'(rdata), 32'd0);

        // Preload addresses 8..11, one requester at a time.
        for (int i = 0; i < N; i++) begin
            d = 8'($urandom_range(1, 255));
            clear_reqs();
            set_req(i, 1'b1, 1'b1, 1'b0, 4'(8 + i), d);
            cycle("pre_wr", 4'(1 << i));
        end
        clear_reqs();

        // 3. All four read continuously: strict rotation.
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b0, 4'(8 + i), '0);
        for (int k = 0; k < 8; k++) cycle("t3_rr", 4'(1 << (k % 4)));
        clear_reqs();
        cycle("t3_drain", 4'b0000);

        // 4. Requester 1 locks for a burst while requester 2 waits.
        set_req(1, 1'b1, 1'b0, 1'b1, 4'd10, '0);
        set_req(2, 1'b1, 1'b1, 1'b0, 4'd12, 8'h3C);
        cycle("t4_lock", 4'b0010);
        cycle("t4_lock", 4'b0010);
        set_req(1, 1'b1, 1'b0, 1'b0, 4'd10, '0);
        cycle("t4_release", 4'b0010);
        chk("t4_ptr_locked", 32'(dbg_ptr), 32'd2);
        cycle("t4_rr", 4'b0100);
        cycle("t4_rr", 4'b0010);
        clear_reqs();
        cycle("t4_drain", 4'b0000);

        // 5. Locked owner beats the pointer, then drops req with 2 pending.
        set_req(1, 1'b1, 1'b0, 1'b1, 4'd10, '0);
        cycle("t5_own", 4'b0010);
        chk("t5_owner_valid", 32'(dbg_owner_valid), 32'd1);
        chk("t5_owner", 32'(dbg_owner), 32'd1);
        set_req(0, 1'b1, 1'b0, 1'b0, 4'd9, '0);
        set_req(2, 1'b1, 1'b0, 1'b0, 4'd11, '0);
        cycle("t5_held", 4'b0010);
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
        cycle("t5_drop", 4'b0100);
        chk("t5_owner_cleared", 32'(dbg_owner_valid), 32'd0);
        clear_reqs();
        cycle("t5_drain", 4'b0000);

        // 6. Async reset right after a read grant completes.
        set_req(1, 1'b1, 1'b0, 1'b0, 4'd8, '0);
        set_req(3, 1'b1, 1'b0, 1'b0, 4'd9, '0);
        cycle("t6_pre", 4'b1000);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_rvalid", 32'(rvalid), 32'd0);
        chk("t6_rst_rdata", 32'(rdata), 32'd0);
        chk("t6_rst_ptr", 32'(dbg_ptr), 32'd0);
        exp_q.delete();
        last_rdata = '0;
        @(posedge clk); #1;
        chk("t6_in_rst_rvalid", 32'(rvalid), 32'd0);
        #2;
        rst = 1'b0;
        cycle("t6_first", 4'b0010);
        clear_reqs();
        cycle("t6_drain", 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
